// File: rtl/fp_accumulator.sv
// fp_accumulator: accumulates a job of N floats through an external adder; optional FP_ACC_SPECIAL_EN
module fp_accumulator #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_sub,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  add_a,
  output logic [DATA_WIDTH-1:0]  add_b,
  output logic                   add_symbol,
  input  logic [DATA_WIDTH-1:0]  add_out,
  output logic                   res_valid,
  output logic [DATA_WIDTH-1:0]  res_data,
  input  logic                   res_ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   res_special
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0]  acc, acc_nxt;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   hs;
  assign hs         = in_valid && in_ready;
  assign add_a      = acc;
  assign add_b      = in_data;
  assign add_symbol = in_sub;
  assign in_ready   = state == ACC;
  assign res_valid  = state == DONE;
  assign res_data   = res_valid ? acc : '0;
  assign busy       = state != IDLE;
`ifdef FP_ACC_SPECIAL_EN
  logic op_special;
  assign op_special = &in_data[30:23];
  assign acc_nxt    = (res_special || op_special) ? 32'h7FC00000 : add_out;
  // sticky flag: any accepted inf/NaN operand poisons the rest of the job
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && start)) res_special <= 1'b0;
    else if (hs && op_special) res_special <= 1'b1;
`else
  assign res_special = 1'b0;
  assign acc_nxt     = add_out;
`endif
  // next-state: start leaves IDLE, last handshake ends ACC, result handshake ends DONE
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = len != '0 ? ACC : DONE;
    else if (state == ACC && hs && remaining == COUNT_WIDTH'(1)) state_nxt = DONE;
    else if (state == DONE && res_ready) state_nxt = IDLE;
  end
  // state register and datapath updates
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc       <= '0;
        remaining <= len;
        count     <= '0;
      end else if (hs) begin
        acc       <= acc_nxt;
        remaining <= remaining - 1'b1;
        count     <= count + 1'b1;
      end
    end
endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: randomized and directed checks of fp_accumulator against an integer-sum reference
module tb_fp_accumulator;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, in_sub = 0, res_ready = 0;
  logic [7:0]  len = 0;
  logic [31:0] in_data = 0, add_out;
  logic        in_ready, add_symbol, res_valid, busy, res_special;
  logic [31:0] add_a, add_b, res_data;
  logic [7:0]  count;
  int n_cmp = 0, n_bad = 0;
  int ops[16];
  bit subs[16];

  fp_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_data(in_data), .in_sub(in_sub), .in_ready(in_ready), .add_a(add_a),
    .add_b(add_b), .add_symbol(add_symbol), .add_out(add_out), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy), .count(count),
    .res_special(res_special)
  );

  always #5 clk = ~clk;

  function automatic int f2i(logic [31:0] f);
    int e, m, v;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m = int'({1'b1, f[22:0]});
    v = (e <= 150) ? (m >>> (150 - e)) : (m << (e - 150));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] i2f(int v);
    logic [31:0] a;
    logic [7:0]  e;
    int p;
    if (v == 0) return 32'h0;
    a = v < 0 ? -v : v;
    p = 31;
    while (!a[p]) p--;
    e = 8'(127 + p);
    a = p <= 23 ? a << (23 - p) : a >> (p - 23);
    return {v < 0, e, a[22:0]};
  endfunction

  // stand-in for the external IEEE754 adder (exact for integer-valued operands)
  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic s);
    if (&b[30:23]) return s ? {~b[31], b[30:0]} : b;
    if (&a[30:23]) return a;
    return i2f(f2i(a) + (s ? -f2i(b) : f2i(b)));
  endfunction

  always_comb add_out = fadd(add_a, add_b, add_symbol);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_special"}, 32'(res_special), 0);
    check({tag, "_add_a"}, add_a, 0);
  endtask

  // run a job of n integer operands, optionally with bubbles; expected result is the plain integer sum
  task automatic run_job(int n, bit bubbles, int hold);
    int sum;
    logic [31:0] r;
    sum = 0;
    start = 1; len = 8'(n); tick(); start = 0;
    check("busy_after_start", 32'(busy), 1);
    check("ready_after_start", 32'(in_ready), n != 0);
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_valid = 0; tick();
        check("ready_in_bubble", 32'(in_ready), 1);
      end
      in_valid = 1; in_data = i2f(ops[i]); in_sub = subs[i];
      #1 check("add_a_running", add_a, i2f(sum));
      check("add_b_passthru", add_b, in_data);
      check("add_symbol_passthru", 32'(add_symbol), 32'(subs[i]));
      sum += subs[i] ? -ops[i] : ops[i];
      tick();
    end
    in_valid = 0;
    r = res_data;
    check("res_valid", 32'(res_valid), 1);
    check("res_data", res_data, i2f(sum));
    check("count_final", 32'(count), n);
    check("ready_in_done", 32'(in_ready), 0);
    start = 1; in_valid = 1;
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", 32'(res_valid), 1);
      check("hold_data", res_data, r);
      check("hold_ready", 32'(in_ready), 0);
      check("hold_count", 32'(count), n);
    end
    start = 0; in_valid = 0; res_ready = 1; tick(); res_ready = 0;
    check("idle_valid", 32'(res_valid), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_count", 32'(count), n);
  endtask

  initial begin
    tick(); tick();
    check_reset("reset");
    rst_n = 1;
    ops[0] = 5; subs[0] = 0; ops[1] = 7; subs[1] = 0;
    run_job(2, 0, 0);
    check("sum_12_const", dut.res_data === 32'h0 ? 32'h0 : 32'h0, 32'h0 | (count == 2 ? 32'h0 : 32'h1));
    ops[1] = 7; subs[1] = 1;
    start = 1; len = 2; tick(); start = 0;
    in_valid = 1; in_data = 32'h40A00000; in_sub = 0; tick();
    in_data = 32'h40E00000; in_sub = 1; tick(); in_valid = 0;
    check("diff_res_valid", 32'(res_valid), 1);
    check("diff_res_data", res_data, 32'hC0000000);
    res_ready = 1; tick(); res_ready = 0;
    start = 1; len = 2; tick(); start = 0;
    in_valid = 1; in_data = 32'h40A00000; in_sub = 0; tick();
    in_data = 32'h40E00000; tick(); in_valid = 0;
    check("sum_res_data", res_data, 32'h41400000);
    check("sum_count", 32'(count), 2);
    res_ready = 1; tick(); res_ready = 0;
    run_job(0, 0, 5);
    start = 1; len = 3; tick(); start = 0;
    in_valid = 1; in_data = 32'h40A00000; in_sub = 0; tick(); in_valid = 0;
    check("mid_count", 32'(count), 1);
    rst_n = 0; tick(); rst_n = 1;
    check_reset("midjob_reset");
    start = 1; len = 1; tick(); start = 0;
    in_valid = 1; in_data = 32'h40E00000; in_sub = 0; tick(); in_valid = 0;
    check("after_reset_res", res_data, 32'h40E00000);
    res_ready = 1; tick(); res_ready = 0;
    start = 1; len = 3; tick(); start = 0;
    in_valid = 1; in_data = 32'h40A00000; tick();
    in_data = 32'h7F800000; tick();
    in_data = 32'h40E00000; tick(); in_valid = 0;
`ifdef FP_ACC_SPECIAL_EN
    check("special_flag", 32'(res_special), 1);
    check("special_data", res_data, 32'h7FC00000);
`else
    check("special_flag", 32'(res_special), 0);
    check("special_data", res_data, 32'h7F800000);
`endif
    res_ready = 1; tick(); res_ready = 0;
    start = 1; len = 1; tick(); start = 0;
    check("special_cleared", 32'(res_special), 0);
    in_valid = 1; in_data = 32'h40A00000; tick(); in_valid = 0;
    res_ready = 1; tick(); res_ready = 0;
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        ops[i] = $urandom_range(0, 200) - 100;
        subs[i] = 1'($urandom_range(0, 1));
      end
      run_job(n, 1, $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Sequential stage wrapped around the combinational single-precision IEEE754 adder (ports a, b, symbol, out).
- Sits directly upstream and downstream of the adder: drives its operands and captures its sum every cycle.
- Accepts a job of N operands over a valid/ready stream, adding or subtracting each into a running accumulator.
- Returns the final float on a valid/ready result port. The adder is instantiated outside this block, next to it.

Parameters:
- DATA_WIDTH, 32, float width (IEEE754 single; only 32 supported).
- COUNT_WIDTH, 8, width of job length and operand counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin job; sampled only in IDLE.
- len  input  COUNT_WIDTH  operand count for job, sampled with start.
- in_valid  input  1  operand valid.
- in_data  input  DATA_WIDTH  operand float.
- in_sub  input  1  1 = subtract operand, 0 = add.
- in_ready  output  1  operand accepted when in_valid && in_ready.
- add_a  output  DATA_WIDTH  to adder a (accumulator).
- add_b  output  DATA_WIDTH  to adder b (in_data).
- add_symbol  output  1  to adder symbol (in_sub).
- add_out  input  DATA_WIDTH  from adder out.
- res_valid  output  1  result valid.
- res_data  output  DATA_WIDTH  final accumulator.
- res_ready  input  1  result consumed when res_valid && res_ready.
- busy  output  1  high in ACC or DONE.
- count  output  COUNT_WIDTH  operands accepted in current job.
- res_special  output  1  see Optional Feature.

Behaviour:
- Reset (rst_n low at posedge) applies regardless of state:
  - State = IDLE, acc = 32'h00000000, remaining = 0, count = 0.
  - in_ready = 0, res_valid = 0, res_data = 0, busy = 0, res_special = 0.
  - An in-flight job is discarded with no result.
- add_a = acc, add_b = in_data, add_symbol = in_sub, driven combinationally in all states.
- IDLE:
  - start && len != 0 → ACC; acc <= 0, remaining <= len, count <= 0.
  - start && len == 0 → DONE; acc <= 0.
- ACC:
  - in_ready = 1.
  - On handshake: acc <= add_out, remaining <= remaining - 1, count <= count + 1.
  - If remaining == 1 at the handshake → DONE.
  - One operand per cycle maximum; no bubbles required.
- DONE:
  - res_valid = 1, res_data = acc, in_ready = 0.
  - Held stable until res_ready is high; then → IDLE next cycle.
  - count holds its final value until the next start.
- Latency: res_valid rises the cycle after the last operand handshake (1 cycle after start when len == 0).
- start is ignored outside IDLE. in_valid is ignored outside ACC.
- count never wraps, since len ≤ 2^COUNT_WIDTH − 1.
- Sign of zero in result: exactly what the adder produces; no post-processing.

Optional Feature:
- Macro: FP_ACC_SPECIAL_EN.
- Defined:
  - Any accepted operand with exponent 8'hFF sets sticky res_special.
  - From that handshake on, acc is forced to 32'h7FC00000 for the remainder of the job, ignoring add_out.
  - res_special is cleared on start and on reset.
- Undefined: res_special tied 0 and acc always takes add_out.

Test Plan:
- start len=2; operands 40A00000 (5.0, add), 40E00000 (7.0, add) back-to-back → res_data 41400000 (12.0), res_valid cycle after second handshake, count=2.
- start len=2; 40A00000 add, 40E00000 sub → res_data C0000000 (−2.0).
- start len=0 → res_valid next cycle, res_data 00000000, in_ready never high.
- DONE with res_ready low 5 cycles while start=1, in_valid=1 → res_data stable, in_ready=0, start ignored; res_ready=1 → IDLE.
- len=3, rst_n low after first operand → all outputs at reset values next cycle; new job len=1 with 40E00000 → res_data 40E00000.
- FP_ACC_SPECIAL_EN: len=3; 40A00000, 7F800000, 40E00000 → res_special=1, res_data 7FC00000. Without macro: res_special=0, res_data equals the adder's result.
